id_token_tracker: RTL
=====================

# id_token_tracker

Token-level post-processor downstream of the identifier recogniser FSM. Consumes the same per-cycle character stream plus the recogniser's registered verdict. Segments the stream into tokens at separator characters, and emits a one-cycle completion pulse with the token length for every token that ends as a valid identifier. Keeps running counts of accepted and rejected tokens, with optional longest-identifier tracking for the lexer statistics path.

## Interface
- LEN_W, 6: width of token-length outputs; lengths saturate at 2^LEN_W-1.
- CNT_W, 8: width of accept/reject counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- char  in  8  ASCII character presented this cycle, one per cycle, always valid.
- id_ok  in  1  recogniser verdict. High when all characters since the last separator, up to and including the previous cycle's char, form a valid identifier.
- tok_valid  out  1  one-cycle pulse: an identifier token just ended.
- tok_len  out  LEN_W  length of the ended identifier; valid only while tok_valid=1, otherwise 0.
- id_count  out  CNT_W  number of accepted identifier tokens.
- rej_count  out  CNT_W  number of non-empty tokens ended with id_ok=0.
- max_len  out  LEN_W  longest accepted identifier length so far (see Configuration).

## Operation
- Character classes: LETTER is 'A'-'Z' (65-90), 'a'-'z' (97-122), or '_' (95). DIGIT is '0'-'9' (48-57). Every other value is SEP.
- FSM states:
  - GAP: between tokens.
  - IN_TOK: inside a token.
- Transitions and actions:
  - GAP, LETTER/DIGIT: go to IN_TOK, run_len := 1.
  - GAP, SEP: stay in GAP, no action.
  - IN_TOK, LETTER/DIGIT: stay in IN_TOK, run_len := run_len+1, saturating.
  - IN_TOK, SEP with id_ok=1: go to GAP, assert tok_valid, tok_len := run_len, id_count += 1 saturating.
  - IN_TOK, SEP with id_ok=0: go to GAP, rej_count += 1 saturating, no pulse.
- Token boundaries are defined only by SEP. A digit-led run such as "1ab" is one token, judged by id_ok.
- Consecutive SEPs produce nothing. Empty tokens are never counted.
- id_ok is sampled only on the SEP cycle that ends a token. Its value during GAP or mid-token is ignored.
- Saturated run_len still reports all-ones. Saturated counters stay at all-ones and never wrap.

## Timing
- All outputs are registered.
- Completion latency: tok_valid rises in the cycle after the edge that sampled the terminating SEP.
- tok_valid lasts exactly one cycle. Back-to-back tokens such as "a b" give pulses two cycles apart.
- Reset values:
  - state = GAP, run_len = 0.
  - tok_valid = 0, tok_len = 0.
  - id_count = 0, rej_count = 0, max_len = 0.
- Reset mid-token discards the partial token, with no pulse and no count. The first non-SEP after reset release starts a new token.
- Reset has priority over every same-edge event.
- A stream ending without a SEP leaves the token open indefinitely. Nothing is emitted until a SEP arrives.

## Configuration
- ID_TRACK_MAXLEN_EN defined: max_len updates on each tok_valid edge to max(max_len, run_len). Rejected tokens never update it.
- Not defined: the max_len register and comparator are removed, and max_len is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package id_pkg holds:
  - enum char_class_t {CC_LETTER, CC_DIGIT, CC_SEP};
  - state enum {ST_GAP, ST_IN_TOK};
  - ASCII bound constants.
- The recogniser shares this package.
- One combinational sub-module, id_char_class: takes char[7:0] and outputs char_class_t. It is reused by the recogniser.
- The top holds the FSM, run_len, counters and the optional max_len.

## Test plan
- Identifier with digits: "abcd1234" then ' ' (32), id_ok=1 at the SEP → one tok_valid, tok_len=8, id_count=1, rej_count=0.
- Rejected token: "1ab" then ' ', id_ok=0 → no pulse, rej_count=1, id_count unchanged.
- Separator handling: "  a  b " with id_ok=1 at each SEP → exactly two pulses, each tok_len=1, id_count=2.
- Saturation (LEN_W=3, CNT_W=2):
  - A 10-letter token gives tok_len=7.
  - Five accepted tokens give id_count=3, still 3 after a sixth.
- Mid-token reset: "abc", then rst_n=0 for one cycle, then "de " → one pulse with tok_len=2, id_count=1.
- max_len build check: tokens of length 3, 5, 2 accepted, then a length-9 rejected token.
  - With ID_TRACK_MAXLEN_EN: max_len=5.
  - Without it: max_len=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the identifier recogniser and token tracker:
// character classes, token FSM states and the ASCII class boundaries.
package id_pkg;

    typedef enum logic [1:0] {
        CC_LETTER,
        CC_DIGIT,
        CC_SEP
    } char_class_t;

    typedef enum logic {
        ST_GAP,
        ST_IN_TOK
    } tok_state_t;

    localparam logic [7:0] ASCII_UPPER_A    = 8'd65;
    localparam logic [7:0] ASCII_UPPER_Z    = 8'd90;
    localparam logic [7:0] ASCII_LOWER_A    = 8'd97;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'd122;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'd95;
    localparam logic [7:0] ASCII_DIGIT_0    = 8'd48;
    localparam logic [7:0] ASCII_DIGIT_9    = 8'd57;

    function automatic logic is_word_class(input char_class_t cc);
        return cc != CC_SEP;
    endfunction

endpackage

// File: rtl/id_char_class.sv
// Combinational ASCII classifier: letters (incl. '_'), digits, everything
// else is a separator. Shared with the identifier recogniser.
module id_char_class
    import id_pkg::*;
(
    input  logic [7:0]  i_char,
    output char_class_t o_class
);

    always_comb begin
        o_class = CC_SEP;
        if ((i_char >= ASCII_UPPER_A && i_char <= ASCII_UPPER_Z) ||
            (i_char >= ASCII_LOWER_A && i_char <= ASCII_LOWER_Z) ||
            (i_char == ASCII_UNDERSCORE)) begin
            o_class = CC_LETTER;
        end else if (i_char >= ASCII_DIGIT_0 && i_char <= ASCII_DIGIT_9) begin
            o_class = CC_DIGIT;
        end
    end

endmodule

// File: rtl/id_token_tracker.sv
// Segments the character stream into tokens at separators and reports accepted
// identifiers. Define ID_TRACK_MAXLEN_EN to keep the longest-identifier register.
module id_token_tracker
    import id_pkg::*;
#(
    parameter int LEN_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             id_ok,
    output logic             tok_valid,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] id_count,
    output logic [CNT_W-1:0] rej_count,
    output logic [LEN_W-1:0] max_len
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    char_class_t      w_class;
    logic             w_is_word;
    tok_state_t       r_state;
    tok_state_t       w_next_state;
    logic             w_accept;
    logic             w_reject;
    logic [LEN_W-1:0] r_run_len;
    logic             r_tok_valid;
    logic [LEN_W-1:0] r_tok_len;
    logic [CNT_W-1:0] r_id_count;
    logic [CNT_W-1:0] r_rej_count;

    id_char_class u_char_class (
        .i_char  (char),
        .o_class (w_class)
    );

    assign w_is_word = is_word_class(w_class);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_GAP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // id_ok only matters on the separator that closes a non-empty token.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_GAP: begin
                if (w_is_word) begin
                    w_next_state = ST_IN_TOK;
                end
            end
            ST_IN_TOK: begin
                if (!w_is_word) begin
                    w_next_state = ST_GAP;
                    w_accept     = id_ok;
                    w_reject     = !id_ok;
                end
            end
            default: w_next_state = ST_GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_len   <= '0;
            r_tok_valid <= 1'b0;
            r_tok_len   <= '0;
            r_id_count  <= '0;
            r_rej_count <= '0;
        end else begin
            r_tok_valid <= w_accept;
            r_tok_len   <= w_accept ? r_run_len : '0;

            if (!w_is_word) begin
                r_run_len <= '0;
            end else if (r_state == ST_GAP) begin
                r_run_len <= LEN_ONE;
            end else if (r_run_len != LEN_MAX) begin
                r_run_len <= r_run_len + LEN_ONE;
            end

            if (w_accept && r_id_count != CNT_MAX) begin
                r_id_count <= r_id_count + CNT_ONE;
            end
            if (w_reject && r_rej_count != CNT_MAX) begin
                r_rej_count <= r_rej_count + CNT_ONE;
            end
        end
    end

`ifdef ID_TRACK_MAXLEN_EN
    logic [LEN_W-1:0] r_max_len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max_len <= '0;
        end else if (w_accept && r_run_len > r_max_len) begin
            r_max_len <= r_run_len;
        end
    end

    assign max_len = r_max_len;
`else
    assign max_len = '0;
`endif

    assign tok_valid = r_tok_valid;
    assign tok_len   = r_tok_len;
    assign id_count  = r_id_count;
    assign rej_count = r_rej_count;

endmodule
